// File: rtl/imem_arb_pkg.sv
// rtl/imem_arb_pkg.sv - shared constants and address check for the instruction memory arbiter
package imem_arb_pkg;

    localparam int PORT_IF    = 0;
    localparam int PORT_LD    = 1;
    localparam int WORD_OFS_W = 2;

    // A request may touch memory only when it is word aligned and inside the array.
    function automatic logic addr_ok(input logic [31:0] addr, input int unsigned mem_words);
        return (addr[WORD_OFS_W-1:0] == '0) && ({2'b00, addr[31:WORD_OFS_W]} < mem_words);
    endfunction

endpackage

// File: rtl/imem_rsp_slot.sv
// rtl/imem_rsp_slot.sv - one-entry registered response buffer with valid/ready handshake
module imem_rsp_slot (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cap_i,
    input  logic [31:0] cap_data_i,
    input  logic        cap_err_i,
    input  logic        rsp_ready_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic        free_o
);

    logic        valid_q, valid_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;

    // A capture in the same cycle as a consume replaces the entry without a bubble.
    assign free_o = !valid_q || rsp_ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        err_d   = err_q;
        if (cap_i) begin
            valid_d = 1'b1;
            data_d  = cap_data_i;
            err_d   = cap_err_i;
        end else if (valid_q && rsp_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid_o = valid_q;
    assign rsp_data_o  = data_q;
    assign rsp_err_o   = err_q;

endmodule

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - LD-priority instruction memory arbiter with IF anti-starvation
// Optional grant/conflict statistics ports under IMEM_ARB_STATS_EN.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned MAX_WAIT  = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_req_valid,
    output logic             if_req_ready,
    input  logic [31:0]      if_req_addr,
    output logic             if_rsp_valid,
    input  logic             if_rsp_ready,
    output logic [31:0]      if_rsp_data,
    output logic             if_rsp_err,
    input  logic             ld_req_valid,
    output logic             ld_req_ready,
    input  logic [31:0]      ld_req_addr,
    output logic             ld_rsp_valid,
    input  logic             ld_rsp_ready,
    output logic [31:0]      ld_rsp_data,
    output logic             ld_rsp_err,
`ifdef IMEM_ARB_STATS_EN
    output logic [CNT_W-1:0] if_grant_cnt,
    output logic [CNT_W-1:0] ld_grant_cnt,
    output logic [CNT_W-1:0] conflict_cnt,
`endif
    output logic             mem_ce,
    output logic [31:0]      mem_addr,
    input  logic [31:0]      mem_data
);

    localparam int unsigned    STW        = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [STW-1:0] STARVE_MAX = STW'(MAX_WAIT);

    logic [1:0]     slot_free, req_v, elig, grant;
    logic [STW-1:0] starve_q, starve_d;
    logic [31:0]    sel_addr, cap_data;
    logic           sel_ok;

    assign req_v[PORT_IF] = if_req_valid;
    assign req_v[PORT_LD] = ld_req_valid;
    // Gating with rst_n keeps the memory idle while reset is asserted.
    assign elig = req_v & slot_free & {2{rst_n}};

    always_comb begin
        grant = '0;
        if (elig[PORT_IF] && (!elig[PORT_LD] || starve_q == STARVE_MAX)) begin
            grant[PORT_IF] = 1'b1;
        end else if (elig[PORT_LD]) begin
            grant[PORT_LD] = 1'b1;
        end
    end

    assign if_req_ready = grant[PORT_IF];
    assign ld_req_ready = grant[PORT_LD];

    assign sel_addr = grant[PORT_LD] ? ld_req_addr : if_req_addr;
    assign sel_ok   = addr_ok(sel_addr, MEM_WORDS);
    assign mem_ce   = (|grant) && sel_ok;
    assign mem_addr = mem_ce ? sel_addr : '0;
    assign cap_data = sel_ok ? mem_data : '0;

    // IF waits are only counted while it could actually have been served.
    always_comb begin
        starve_d = starve_q;
        if (!if_req_valid || grant[PORT_IF]) begin
            starve_d = '0;
        end else if (elig[PORT_IF] && starve_q != STARVE_MAX) begin
            starve_d = starve_q + STW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    imem_rsp_slot u_if_slot (
        .clk         (clk),
        .rst_n       (rst_n),
        .cap_i       (grant[PORT_IF]),
        .cap_data_i  (cap_data),
        .cap_err_i   (!sel_ok),
        .rsp_ready_i (if_rsp_ready),
        .rsp_valid_o (if_rsp_valid),
        .rsp_data_o  (if_rsp_data),
        .rsp_err_o   (if_rsp_err),
        .free_o      (slot_free[PORT_IF])
    );

    imem_rsp_slot u_ld_slot (
        .clk         (clk),
        .rst_n       (rst_n),
        .cap_i       (grant[PORT_LD]),
        .cap_data_i  (cap_data),
        .cap_err_i   (!sel_ok),
        .rsp_ready_i (ld_rsp_ready),
        .rsp_valid_o (ld_rsp_valid),
        .rsp_data_o  (ld_rsp_data),
        .rsp_err_o   (ld_rsp_err),
        .free_o      (slot_free[PORT_LD])
    );

`ifdef IMEM_ARB_STATS_EN
    logic [CNT_W-1:0] if_cnt_q, ld_cnt_q, cf_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_cnt_q <= '0;
            ld_cnt_q <= '0;
            cf_cnt_q <= '0;
        end else begin
            if (grant[PORT_IF] && if_cnt_q != '1) if_cnt_q <= if_cnt_q + CNT_W'(1);
            if (grant[PORT_LD] && ld_cnt_q != '1) ld_cnt_q <= ld_cnt_q + CNT_W'(1);
            if ((&elig) && cf_cnt_q != '1)        cf_cnt_q <= cf_cnt_q + CNT_W'(1);
        end
    end

    assign if_grant_cnt = if_cnt_q;
    assign ld_grant_cnt = ld_cnt_q;
    assign conflict_cnt = cf_cnt_q;
`endif

endmodule
